count_run_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit up-counter between two requesters. A granted requester receives one count run from 0 up to its own programmed limit, followed by a one-cycle done pulse. The block sits between the requesting engines and the counter datapath: it grants the counter, loads the limit, steps the count, and releases the counter when the run finishes.

---
 rtl/count_run_arbiter.sv | 121 ++++++++++++
 tb/tb_count_run_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_run_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit up-counter between two requesters; each grant runs 0..limit, then pulses done.
// Optional pause input is compiled in with CNT_ARB_PAUSE_EN. Grant one edge after req. All outputs are registered.
// Backpressure: a requester holds req until done or drops it to abort; the losing requester stays pending.
module count_run_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] limit0,
    input  logic [WIDTH-1:0] limit1,
`ifdef CNT_ARB_PAUSE_EN
    input  logic             pause,
`endif
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] cnt_out,
    output logic             cnt_valid,
    output logic [1:0]       done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_nxt;
    logic             winner, winner_nxt;
    logic             rr, rr_nxt;
    logic [WIDTH-1:0] lim, lim_nxt;
    logic [1:0]       gnt_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             valid_nxt;
    logic [1:0]       done_nxt;
    logic             pick;
    logic [1:0]       pick_oh;
    logic [WIDTH-1:0] pick_lim;
    logic [WIDTH-1:0] cnt_inc;
    logic             paused;

`ifdef CNT_ARB_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    assign cnt_inc = cnt_out + {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        pick = rr;
        if (req == 2'b01)
            pick = 1'b0;
        else if (req == 2'b10)
            pick = 1'b1;
        pick_oh  = pick ? 2'b10 : 2'b01;
        pick_lim = pick ? limit1 : limit0;
    end

    always_comb begin
        state_nxt  = state;
        winner_nxt = winner;
        rr_nxt     = rr;
        lim_nxt    = lim;
        gnt_nxt    = gnt;
        cnt_nxt    = cnt_out;
        valid_nxt  = cnt_valid;
        done_nxt   = 2'b00;
        case (state)
            IDLE: begin
                gnt_nxt   = 2'b00;
                cnt_nxt   = '0;
                valid_nxt = 1'b0;
                if (|req) begin
                    state_nxt  = RUN;
                    winner_nxt = pick;
                    gnt_nxt    = pick_oh;
                    valid_nxt  = 1'b1;
                    lim_nxt    = pick_lim;
                    // A zero limit finishes in the grant cycle itself.
                    done_nxt   = (pick_lim == '0) ? pick_oh : 2'b00;
                end
            end
            RUN: begin
                // Leave after the done cycle or as soon as the winner withdraws.
                if (!req[winner] || (|done)) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 2'b00;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b0;
                    rr_nxt    = ~winner;
                end else if (paused) begin
                    valid_nxt = 1'b0;
                end else begin
                    cnt_nxt   = cnt_inc;
                    valid_nxt = 1'b1;
                    done_nxt  = (cnt_inc == lim) ? gnt : 2'b00;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            winner    <= 1'b0;
            rr        <= 1'b0;
            lim       <= '0;
            gnt       <= 2'b00;
            cnt_out   <= '0;
            cnt_valid <= 1'b0;
            done      <= 2'b00;
        end else begin
            state     <= state_nxt;
            winner    <= winner_nxt;
            rr        <= rr_nxt;
            lim       <= lim_nxt;
            gnt       <= gnt_nxt;
            cnt_out   <= cnt_nxt;
            cnt_valid <= valid_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_count_run_arbiter.sv
// Directed bench for count_run_arbiter; the pause scenario is built only with CNT_ARB_PAUSE_EN.
module tb_count_run_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [2:0] limit0;
    logic [2:0] limit1;
    logic       pause;
    logic [1:0] gnt;
    logic [2:0] cnt_out;
    logic       cnt_valid;
    logic [1:0] done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    count_run_arbiter #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .limit0    (limit0),
        .limit1    (limit1),
`ifdef CNT_ARB_PAUSE_EN
        .pause     (pause),
`endif
        .gnt       (gnt),
        .cnt_out   (cnt_out),
        .cnt_valid (cnt_valid),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 2'b00; limit0 = 3'd0; limit1 = 3'd0; pause = 1'b0;
        do_reset();
        n_cmp++;
        if ({gnt, cnt_out, cnt_valid, done} !== 8'b0) begin
            n_err++;
            $display("FAIL reset: gnt=%b cnt=%0d vld=%b done=%b, want all 0", gnt, cnt_out, cnt_valid, done);
        end
        tick();
        n_cmp++;
        if (gnt !== 2'b00) begin
            n_err++;
            $display("FAIL idle_no_req: gnt=%b want 00", gnt);
        end
    endtask

    task automatic test_single();
        req = 2'b01; limit0 = 3'd3;
        tick();
        for (int i = 0; i <= 3; i++) begin
            n_cmp++;
            if (gnt !== 2'b01 || cnt_out !== 3'(i) || cnt_valid !== 1'b1 || done !== ((i == 3) ? 2'b01 : 2'b00)) begin
                n_err++;
                $display("FAIL single_run[%0d]: gnt=%b cnt=%0d vld=%b done=%b, want 01 %0d 1 %b",
                         i, gnt, cnt_out, cnt_valid, done, i, (i == 3) ? 2'b01 : 2'b00);
            end
            if (i == 3) req = 2'b00;
            tick();
        end
        n_cmp++;
        if (gnt !== 2'b00 || cnt_valid !== 1'b0 || cnt_out !== 3'd0 || done !== 2'b00) begin
            n_err++;
            $display("FAIL single_release: gnt=%b vld=%b cnt=%0d done=%b, want 00 0 0 00", gnt, cnt_valid, cnt_out, done);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt  [8];
        logic [1:0] exp_done [8];
        exp_gnt  = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        exp_done = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        do_reset();
        req = 2'b11; limit0 = 3'd1; limit1 = 3'd2;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (gnt !== exp_gnt[i] || done !== exp_done[i]) begin
                n_err++;
                $display("FAIL round_robin[%0d]: gnt=%b done=%b, want %b %b", i, gnt, done, exp_gnt[i], exp_done[i]);
            end
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_limit0();
        req = 2'b10; limit1 = 3'd0;
        tick();
        n_cmp++;
        if (gnt !== 2'b10 || cnt_out !== 3'd0 || cnt_valid !== 1'b1 || done !== 2'b10) begin
            n_err++;
            $display("FAIL limit0_run: gnt=%b cnt=%0d vld=%b done=%b, want 10 0 1 10", gnt, cnt_out, cnt_valid, done);
        end
        req = 2'b00;
        tick();
        n_cmp++;
        if (gnt !== 2'b00 || done !== 2'b00) begin
            n_err++;
            $display("FAIL limit0_release: gnt=%b done=%b, want 00 00", gnt, done);
        end
    endtask

    task automatic test_abort();
        do_reset();
        req = 2'b11; limit0 = 3'd7;
        tick();
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (gnt !== 2'b01 || cnt_out !== 3'd4 || done !== 2'b00) begin
            n_err++;
            $display("FAIL abort_pre: gnt=%b cnt=%0d done=%b, want 01 4 00", gnt, cnt_out, done);
        end
        req = 2'b10;
        tick();
        n_cmp++;
        if (gnt !== 2'b00 || done !== 2'b00 || cnt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_release: gnt=%b done=%b vld=%b, want 00 00 0", gnt, done, cnt_valid);
        end
        tick();
        n_cmp++;
        if (gnt !== 2'b10 || cnt_out !== 3'd0) begin
            n_err++;
            $display("FAIL abort_pending: gnt=%b cnt=%0d, want 10 0", gnt, cnt_out);
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_rst_mid_run();
        req = 2'b11; limit0 = 3'd7;
        tick();
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (cnt_out !== 3'd5 || gnt !== 2'b01) begin
            n_err++;
            $display("FAIL rst_pre: cnt=%0d gnt=%b, want 5 01", cnt_out, gnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({gnt, cnt_out, cnt_valid, done} !== 8'b0) begin
            n_err++;
            $display("FAIL rst_mid: gnt=%b cnt=%0d vld=%b done=%b, want all 0", gnt, cnt_out, cnt_valid, done);
        end
        tick();
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_err++;
            $display("FAIL rst_rr: gnt=%b want 01", gnt);
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_full_run();
        req = 2'b01; limit0 = 3'd7;
        tick();
        limit0 = 3'd2;
        for (int i = 0; i <= 7; i++) begin
            n_cmp++;
            if (gnt !== 2'b01 || cnt_out !== 3'(i) || done !== ((i == 7) ? 2'b01 : 2'b00)) begin
                n_err++;
                $display("FAIL full_run[%0d]: gnt=%b cnt=%0d done=%b, want 01 %0d %b",
                         i, gnt, cnt_out, done, i, (i == 7) ? 2'b01 : 2'b00);
            end
            tick();
        end
        n_cmp++;
        if (gnt !== 2'b00 || cnt_out !== 3'd0) begin
            n_err++;
            $display("FAIL full_release: gnt=%b cnt=%0d, want 00 0", gnt, cnt_out);
        end
        req = 2'b00;
        tick();
    endtask

`ifdef CNT_ARB_PAUSE_EN
    task automatic test_pause();
        logic [2:0] exp_cnt  [6];
        logic       exp_vld  [6];
        logic [1:0] exp_done [6];
        exp_cnt  = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
        exp_vld  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_done = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        do_reset();
        req = 2'b01; limit0 = 3'd3;
        for (int i = 0; i < 6; i++) begin
            pause = (i == 3 || i == 4);
            tick();
            n_cmp++;
            if (gnt !== 2'b01 || cnt_out !== exp_cnt[i] || cnt_valid !== exp_vld[i] || done !== exp_done[i]) begin
                n_err++;
                $display("FAIL pause[%0d]: gnt=%b cnt=%0d vld=%b done=%b, want 01 %0d %b %b",
                         i, gnt, cnt_out, cnt_valid, done, exp_cnt[i], exp_vld[i], exp_done[i]);
            end
        end
        pause = 1'b0;
        req = 2'b00;
        tick();
        n_cmp++;
        if (gnt !== 2'b00) begin
            n_err++;
            $display("FAIL pause_release: gnt=%b want 00", gnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; req = 2'b00; limit0 = 3'd0; limit1 = 3'd0; pause = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_limit0();
        test_abort();
        test_rst_mid_run();
        test_full_run();
`ifdef CNT_ARB_PAUSE_EN
        test_pause();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
